// File: rtl/du_pkg.sv
// ---------------------------------------------------------------------------
// du_pkg
// Shared constants for the debug-unit program loader: protocol bytes and the
// loader FSM state encoding (also shown on the debug LEDs through o_state).
// ---------------------------------------------------------------------------
package du_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEN_HI    = 3'd1,
        ST_LEN_LO    = 3'd2,
        ST_DATA      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_SEND_RESP = 3'd5,
        ST_WAIT_TX   = 3'd6
    } state_t;

endpackage

// File: rtl/du_word_packer.sv
// ---------------------------------------------------------------------------
// du_word_packer
// Collects NB_DATA/NB_BYTE bytes, least-significant lane first, into one word.
//
// Ports:
//   i_clock, i_reset  clock and asynchronous active-low reset
//   i_clear           zero the lane index and word (start of a new load)
//   i_byte_valid      one-cycle strobe, i_byte_data is consumed this cycle
//   i_byte_data       incoming byte
//   o_word            word including the byte being consumed this cycle
//   o_word_valid      high when the consumed byte completes the word
//
// o_word/o_word_valid are combinational so the loader can register the
// memory write on the same edge that consumes the last byte.
// ---------------------------------------------------------------------------
module du_word_packer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte_data,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid
);

    localparam int LANES  = NB_DATA / NB_BYTE;
    localparam int NB_IDX = $clog2(LANES);

    logic [NB_DATA-1:0] word_q;
    logic [NB_IDX-1:0]  byte_idx;

    always_comb begin
        o_word = word_q;
        o_word[byte_idx*NB_BYTE +: NB_BYTE] = i_byte_data;
    end

    assign o_word_valid = i_byte_valid && (byte_idx == NB_IDX'(LANES - 1));

    // The index wraps naturally after the last lane; earlier lanes of the next
    // word are overwritten one by one, so no explicit clear between words.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (i_clear) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (i_byte_valid) begin
            word_q   <= o_word;
            byte_idx <= byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/du_program_loader.sv
// ---------------------------------------------------------------------------
// du_program_loader
// Receives a load command from the UART receiver, writes the payload words
// into instruction memory at consecutive addresses starting at 0, checks an
// XOR checksum over all data bytes and answers with ACK (0x06) or NAK (0x15).
//
// Command format: 'L', count_hi, count_lo, count words x 4 bytes (LSB first),
// checksum byte.
//
// Ports:
//   i_clock, i_reset       clock, asynchronous active-low reset
//   i_rx_data, i_rx_done   received byte and its one-cycle strobe
//   i_tx_done              UART finished sending the response byte
//   o_tx_data, o_tx_start  response byte and one-cycle send request
//   o_imem_wr_en/addr/wr_data  instruction-memory write port
//   o_loading              load in progress (LEN_HI..CHECK)
//   o_load_done            one-cycle pulse after an ACK has been sent
//   o_error                last load failed (sticky until the next 'L')
//   o_state                FSM state for debug LEDs
//
// Handshake: every strobe (i_rx_done, i_tx_done, o_tx_start, o_imem_wr_en) is
// a single-cycle pulse with data valid in the same cycle; there is no ready
// or back-pressure, a strobe not wanted in the current state is dropped.
// ---------------------------------------------------------------------------
module du_program_loader
    import du_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8,
    parameter int NB_ADDR  = 10,
    parameter int NB_STATE = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_start,
    output logic                o_imem_wr_en,
    output logic [NB_ADDR-1:0]  o_imem_addr,
    output logic [NB_DATA-1:0]  o_imem_wr_data,
    output logic                o_loading,
    output logic                o_load_done,
    output logic                o_error,
    output logic [NB_STATE-1:0] o_state
);

    localparam int          NB_COUNT  = 2 * NB_BYTE;
    localparam int unsigned MAX_WORDS = 32'd1 << NB_ADDR;

    state_t              state;
    logic [NB_BYTE-1:0]  count_hi;
    logic [NB_COUNT-1:0] count;
    logic [NB_COUNT-1:0] len_word;
    // One extra bit so the counter can reach 2^NB_ADDR without wrapping.
    logic [NB_ADDR:0]    addr;
    logic [NB_ADDR:0]    addr_next;
    logic [NB_BYTE-1:0]  checksum;
    logic [NB_BYTE-1:0]  resp;

    logic                start_load;
    logic                pack_valid;
    logic [NB_DATA-1:0]  pack_word;
    logic                pack_word_valid;

    assign start_load = (state == ST_IDLE) && i_rx_done && (i_rx_data == CMD_LOAD);
    assign pack_valid = (state == ST_DATA) && i_rx_done;
    assign len_word   = {count_hi, i_rx_data};
    assign addr_next  = addr + 1'b1;
    assign o_state    = NB_STATE'(state);

    du_word_packer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (start_load),
        .i_byte_valid (pack_valid),
        .i_byte_data  (i_rx_data),
        .o_word       (pack_word),
        .o_word_valid (pack_word_valid)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ST_IDLE;
            count_hi       <= '0;
            count          <= '0;
            addr           <= '0;
            checksum       <= '0;
            resp           <= '0;
            o_tx_data      <= '0;
            o_tx_start     <= 1'b0;
            o_imem_wr_en   <= 1'b0;
            o_imem_addr    <= '0;
            o_imem_wr_data <= '0;
            o_loading      <= 1'b0;
            o_load_done    <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_tx_start   <= 1'b0;
            o_imem_wr_en <= 1'b0;
            o_load_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_load) begin
                        state     <= ST_LEN_HI;
                        o_loading <= 1'b1;
                        o_error   <= 1'b0;
                        checksum  <= '0;
                        addr      <= '0;
                    end
                end

                ST_LEN_HI: begin
                    if (i_rx_done) begin
                        count_hi <= i_rx_data;
                        state    <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (i_rx_done) begin
                        count <= len_word;
                        if (32'(len_word) > MAX_WORDS) begin
                            // Payload would not fit: refuse before any write.
                            resp      <= NAK;
                            o_error   <= 1'b1;
                            o_loading <= 1'b0;
                            state     <= ST_SEND_RESP;
                        end else if (len_word == '0) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (i_rx_done) begin
                        checksum <= checksum ^ i_rx_data;
                        if (pack_word_valid) begin
                            o_imem_wr_en   <= 1'b1;
                            o_imem_addr    <= addr[NB_ADDR-1:0];
                            o_imem_wr_data <= pack_word;
                            addr           <= addr_next;
                            if (32'(addr_next) == 32'(count)) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end

                ST_CHECK: begin
                    if (i_rx_done) begin
                        o_loading <= 1'b0;
                        state     <= ST_SEND_RESP;
                        if (i_rx_data == checksum) begin
                            resp <= ACK;
                        end else begin
                            resp    <= NAK;
                            o_error <= 1'b1;
                        end
                    end
                end

                ST_SEND_RESP: begin
                    o_tx_data  <= resp;
                    o_tx_start <= 1'b1;
                    state      <= ST_WAIT_TX;
                end

                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        state <= ST_IDLE;
                        if (resp == ACK) begin
                            o_load_done <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_du_program_loader.sv
// ---------------------------------------------------------------------------
// tb_du_program_loader
// Drives load commands byte by byte and compares memory writes, response
// bytes and status flags against a protocol-level reference model.
// ---------------------------------------------------------------------------
module tb_du_program_loader;

    localparam int NB_DATA  = 32;
    localparam int NB_BYTE  = 8;
    localparam int NB_ADDR  = 10;
    localparam int NB_STATE = 3;
    localparam int MAX_N    = 1 << NB_ADDR;

    localparam logic [7:0] B_CMD = 8'h4C;
    localparam logic [7:0] B_ACK = 8'h06;
    localparam logic [7:0] B_NAK = 8'h15;

    // ---------------- clock / reset ----------------
    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clock = ~i_clock;

    logic [NB_BYTE-1:0]  i_rx_data = '0;
    logic                i_rx_done = 1'b0;
    logic                i_tx_done = 1'b0;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                o_tx_start;
    logic                o_imem_wr_en;
    logic [NB_ADDR-1:0]  o_imem_addr;
    logic [NB_DATA-1:0]  o_imem_wr_data;
    logic                o_loading;
    logic                o_load_done;
    logic                o_error;
    logic [NB_STATE-1:0] o_state;

    du_program_loader #(
        .NB_DATA  (NB_DATA),
        .NB_BYTE  (NB_BYTE),
        .NB_ADDR  (NB_ADDR),
        .NB_STATE (NB_STATE)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx_data      (i_rx_data),
        .i_rx_done      (i_rx_done),
        .i_tx_done      (i_tx_done),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_imem_wr_en   (o_imem_wr_en),
        .o_imem_addr    (o_imem_addr),
        .o_imem_wr_data (o_imem_wr_data),
        .o_loading      (o_loading),
        .o_load_done    (o_load_done),
        .o_error        (o_error),
        .o_state        (o_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit tx_seen  = 1'b0;

    logic [NB_ADDR+NB_DATA-1:0] exp_q[$];     // expected writes {addr, data}
    logic [NB_BYTE-1:0]         exp_tx_q[$];  // expected response bytes
    logic [NB_DATA-1:0]         words[$];     // payload of the next load
    logic [NB_ADDR+NB_DATA-1:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clock) begin
        if (i_reset) begin
            if (o_imem_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(o_imem_addr), 64'(mon_e[NB_ADDR+NB_DATA-1:NB_DATA]));
                    check("wr_data", 64'(o_imem_wr_data), 64'(mon_e[NB_DATA-1:0]));
                end
            end
            if (o_tx_start) begin
                tx_seen = 1'b1;
                if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_data", 64'(o_tx_data), 64'(exp_tx_q.pop_front()));
            end
            if (o_load_done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    // i_tx_done is occasionally pulsed alongside bytes; outside WAIT_TX the
    // loader must ignore it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clock);
        i_rx_data = b;
        i_rx_done = 1'b1;
        i_tx_done = ($urandom_range(0, 7) == 0);
        @(negedge i_clock);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge i_clock);
    endtask

    // Model: a count above MAX_N is refused right after the count bytes;
    // otherwise every word i lands at address i, and the load is acked only
    // if the checksum byte equals the XOR of all data bytes.
    task automatic do_load(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        logic [7:0] resp;
        bit         ok;
        int         d0;
        cs      = 8'h00;
        d0      = done_cnt;
        tx_seen = 1'b0;
        send_byte(B_CMD);
        check("loading_after_cmd", 64'(o_loading), 1);
        check("error_cleared", 64'(o_error), 0);
        check("state_len_hi", 64'(o_state), 1);
        b = n[15:8];
        send_byte(b);
        b = n[7:0];
        send_byte(b);
        if (n > MAX_N) begin
            ok   = 1'b0;
            resp = B_NAK;
            exp_tx_q.push_back(resp);
        end else begin
            ok   = !corrupt;
            resp = ok ? B_ACK : B_NAK;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({NB_ADDR'(i), words[i]});
                for (int j = 0; j < 4; j++) begin
                    b  = words[i][8*j +: 8];
                    cs = cs ^ b;
                    send_byte(b);
                end
            end
            exp_tx_q.push_back(resp);
            send_byte(cs ^ {7'b0, corrupt});
        end
        for (int k = 0; k < 50 && !tx_seen; k++) @(negedge i_clock);
        check("tx_seen", 64'(tx_seen), 1);
        repeat ($urandom_range(0, 4)) @(negedge i_clock);
        check("tx_data_hold", 64'(o_tx_data), 64'(resp));
        check("state_wait_tx", 64'(o_state), 6);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        repeat (2) @(negedge i_clock);
        check("load_done_count", 64'(done_cnt - d0), 64'(ok));
        check("error_flag", 64'(o_error), 64'(!ok));
        check("state_idle", 64'(o_state), 0);
        check("loading_idle", 64'(o_loading), 0);
        check("writes_drained", 64'(exp_q.size()), 0);
        words.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge i_clock);
        check("rst_state", 64'(o_state), 0);
        check("rst_tx_start", 64'(o_tx_start), 0);
        check("rst_wr_en", 64'(o_imem_wr_en), 0);
        check("rst_loading", 64'(o_loading), 0);
        check("rst_error", 64'(o_error), 0);
        check("rst_tx_data", 64'(o_tx_data), 0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);

        // Reference load; these 8 bytes XOR to 0x2A.
        words.push_back(32'h12345678);
        words.push_back(32'hDEADBEEF);
        do_load(2, 1'b0);

        // Same payload, wrong checksum: writes still happen, NAK, error set.
        words.push_back(32'h12345678);
        words.push_back(32'hDEADBEEF);
        do_load(2, 1'b1);

        // Count one past the memory size.
        do_load(MAX_N + 1, 1'b0);

        // Empty load with checksum 0.
        do_load(0, 1'b0);

        // Garbage in IDLE changes nothing.
        send_byte(8'h00);
        send_byte(8'h41);
        repeat (3) @(negedge i_clock);
        check("garbage_state", 64'(o_state), 0);
        check("garbage_loading", 64'(o_loading), 0);
        check("garbage_no_tx", 64'(exp_tx_q.size()), 0);
        words.push_back($urandom);
        do_load(1, 1'b0);

        // Random loads.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) words.push_back($urandom);
            do_load(n, bit'($urandom_range(0, 1)));
        end

        // Largest legal load fills every address; 0xFFFF is refused.
        for (int i = 0; i < MAX_N; i++) words.push_back($urandom);
        do_load(MAX_N, 1'b0);
        do_load(16'hFFFF, 1'b0);

        // Reset after 6 data bytes: only word 0 reaches memory.
        words.push_back(32'hA1B2C3D4);
        words.push_back(32'h55667788);
        send_byte(B_CMD);
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back({NB_ADDR'(0), words[0]});
        for (int j = 0; j < 4; j++) send_byte(words[0][8*j +: 8]);
        send_byte(words[1][7:0]);
        send_byte(words[1][15:8]);
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("midrst_state", 64'(o_state), 0);
        check("midrst_wr_en", 64'(o_imem_wr_en), 0);
        check("midrst_addr", 64'(o_imem_addr), 0);
        check("midrst_wr_data", 64'(o_imem_wr_data), 0);
        check("midrst_loading", 64'(o_loading), 0);
        check("midrst_error", 64'(o_error), 0);
        check("midrst_tx_start", 64'(o_tx_start), 0);
        check("midrst_load_done", 64'(o_load_done), 0);
        check("midrst_only_word0", 64'(exp_q.size()), 0);
        exp_q.delete();
        words.delete();
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);

        // Fresh load restarts at address 0.
        words.push_back(32'hCAFEF00D);
        words.push_back(32'h0BADC0DE);
        words.push_back(32'h00000001);
        do_load(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
